branch_control_unit: RTL and testbench

- Hardwired control sequencer for the datapath; the control-side counterpart of the datapath's signal interface.
- Drives the datapath's control vectors (enable, busSelect, Control_Signals, Gra/Grb/Grc/Rin/Rout/BAout, MD_Read/ReadRAM/WriteRAM).
- Sequences instruction fetch, then executes the conditional branch (brzr/brnz/brpl/brmi), nop and halt from IR contents plus the CON flip-flop result.
- Sits beside datapath at CPU top level; replaces hand-driven testbench control.

---
 rtl/branch_control_unit.sv | 151 +++++++++++++++
 tb/tb_branch_control_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// rtl/branch_control_unit.sv - hardwired fetch/branch/nop/halt control sequencer for the datapath
module branch_control_unit #(
    parameter logic [4:0] OP_BR     = 5'b10011,
    parameter logic [4:0] OP_NOP    = 5'b11010,
    parameter logic [4:0] OP_HALT   = 5'b11011,
    parameter logic [4:0] ALU_ADD   = 5'd1,
    parameter logic [4:0] ALU_INCPC = 5'd14
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        con,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic [3:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] br_taken_cnt
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8,
        S_DEC  = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_d;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            illegal      <= 1'b0;
            br_taken_cnt <= 16'h0000;
        end else begin
            state_q <= state_d;
            illegal <= illegal_d;
            if (state_q == S_T6 && con && br_taken_cnt != 16'hFFFF)
                br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end

    // IR is only stable one cycle after its T2 load, so the opcode is decoded in DEC.
    always_comb begin
        state_d   = S_IDLE;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = run ? S_T0 : S_IDLE;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_DEC;
            S_DEC: begin
                if (opcode == OP_BR)        state_d = S_T3;
                else if (opcode == OP_NOP)  state_d = S_IDLE;
                else if (opcode == OP_HALT) state_d = S_HALT;
                else begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = S_T6;
            S_T6:   state_d = S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable          = 32'h0;
        busSelect       = 32'h0;
        Control_Signals = 5'd0;
        Gra             = 1'b0;
        Rout            = 1'b0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        halted          = 1'b0;
        case (state_q)
            S_T0: begin
                busSelect[20]   = 1'b1;
                enable[25]      = 1'b1;
                enable[18]      = 1'b1;
                Control_Signals = ALU_INCPC;
            end
            S_T1: begin
                busSelect[19] = 1'b1;
                enable[20]    = 1'b1;
                enable[21]    = 1'b1;
                MD_Read       = 1'b1;
                ReadRAM       = 1'b1;
            end
            S_T2: begin
                busSelect[21] = 1'b1;
                enable[24]    = 1'b1;
            end
            S_T3: begin
                Gra          = 1'b1;
                Rout         = 1'b1;
                busSelect[0] = 1'b1;
                enable[27]   = 1'b1;
            end
            S_T4: begin
                busSelect[20] = 1'b1;
                enable[19]    = 1'b1;
            end
            S_T5: begin
                busSelect[23]   = 1'b1;
                Control_Signals = ALU_ADD;
                enable[18]      = 1'b1;
            end
            S_T6: begin
                busSelect[19] = 1'b1;
                enable[20]    = con;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign Grb      = 1'b0;
    assign Grc      = 1'b0;
    assign Rin      = 1'b0;
    assign BAout    = 1'b0;
    assign WriteRAM = 1'b0;
    assign state    = state_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// tb/tb_branch_control_unit.sv - randomized self-checking bench for branch_control_unit
module tb_branch_control_unit;

    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic        clk = 1'b0;
    logic        clr, run, con;
    logic [31:0] ir;
    logic [31:0] enable, busSelect;
    logic [4:0]  Control_Signals;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM;
    logic [3:0]  state;
    logic        halted, illegal;
    logic [15:0] br_taken_cnt;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    always #5 clk = ~clk;

    branch_control_unit dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .con(con),
        .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
        .state(state), .halted(halted), .illegal(illegal), .br_taken_cnt(br_taken_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs per state code; misc = {alu, Gra,Grb,Grc,Rin,Rout,BAout,MD_Read,ReadRAM,WriteRAM,halted}
    task automatic check_cycle(input int st, input logic c, input logic exp_ill);
        logic [31:0] en, bs;
        logic [14:0] misc;
        en = 0; bs = 0; misc = 0;
        case (st)
            1: begin bs = 32'h1 << 20; en = (32'h1 << 25) | (32'h1 << 18); misc[14:10] = 5'd14; end
            2: begin bs = 32'h1 << 19; en = (32'h1 << 20) | (32'h1 << 21); misc[3] = 1'b1; misc[2] = 1'b1; end
            3: begin bs = 32'h1 << 21; en = 32'h1 << 24; end
            4: begin bs = 32'h1; en = 32'h1 << 27; misc[9] = 1'b1; misc[5] = 1'b1; end
            5: begin bs = 32'h1 << 20; en = 32'h1 << 19; end
            6: begin bs = 32'h1 << 23; en = 32'h1 << 18; misc[14:10] = 5'd1; end
            7: begin bs = 32'h1 << 19; en = {11'b0, c, 20'b0}; end
            8: misc[0] = 1'b1;
            default: ;
        endcase
        check("state", 64'(state), 64'(st));
        check("enable", 64'(enable), 64'(en));
        check("busSelect", 64'(busSelect), 64'(bs));
        check("ctrl", 64'({Control_Signals, Gra, Grb, Grc, Rin, Rout, BAout,
                           MD_Read, ReadRAM, WriteRAM, halted}), 64'(misc));
        check("illegal", 64'(illegal), 64'(exp_ill));
        check("br_taken_cnt", 64'(br_taken_cnt), 64'(exp_cnt));
    endtask

    // Runs one instruction from IDLE; abort_at >= 0 asserts clr after that step of the sequence.
    task automatic do_instr(input logic [31:0] iv, input logic cv, input int abort_at);
        int   q[$];
        logic ill;
        logic [4:0] op;
        op  = iv[31:27];
        ill = (op != OP_BR) && (op != OP_NOP) && (op != OP_HALT);
        q = {1, 2, 3, 9};
        if (op == OP_BR) q = {q, 4, 5, 6, 7};
        if (op == OP_HALT) begin
            for (int k = 0; k < 20; k++) q.push_back(8);
        end else begin
            q.push_back(0);
        end
        ir = iv; con = cv; run = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            check_cycle(q[i], cv, ill && q[i] == 0);
            if (q[i] == 7 && cv && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            run = (q[i] == 8) ? 1'b1 : 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                clr = 1'b1;
                @(negedge clk);
                exp_cnt = 16'h0000;
                check_cycle(0, 1'b0, 1'b0);
                clr = 1'b0;
                run = 1'b0;
                return;
            end
        end
        run = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        clr = 1'b1; run = 1'b0; ir = 32'h0; con = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_cycle(0, 1'b0, 1'b0);
        end

        do_instr(32'h9B000019, 1'b1, -1);
        do_instr(32'h9B080019, 1'b0, -1);
        do_instr(32'hD0000000, 1'b0, -1);
        do_instr({5'b11111, 27'h0}, 1'b0, -1);
        do_instr(32'h9B000019, 1'b1, -1);
        do_instr(32'h9B000019, 1'b1, 5);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: op = OP_BR;
                2:    op = OP_NOP;
                default: begin
                    op = 5'($urandom);
                    while (op == OP_BR || op == OP_NOP || op == OP_HALT) op = 5'($urandom);
                end
            endcase
            do_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1);
        end

        force dut.br_taken_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.br_taken_cnt;
        exp_cnt = 16'hFFFF;
        check_cycle(0, 1'b0, 1'b0);
        do_instr(32'h9B000019, 1'b1, -1);
        do_instr(32'h9B000019, 1'b1, -1);

        do_instr(32'hD8000000, 1'b0, 23);
        do_instr(32'h9B000019, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
